game_text_line_driver: RTL



---
 rtl/game_text_pkg.sv | 42 ++++
 rtl/game_text_rom.sv | 77 +++++++
 rtl/game_text_line_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/game_text_pkg.sv
// Shared definitions for the text line driver and its message ROM.
// Contents: letter codes understood by the letter bitmap, letter width,
// driver state encoding and the message selector type.
package game_text_pkg;

   localparam int LETTER_W = 6;

   typedef enum logic [LETTER_W-1:0] {
      BLANK = 6'd0,
      P     = 6'd1,
      R     = 6'd2,
      E     = 6'd3,
      S     = 6'd4,
      A     = 6'd5,
      C     = 6'd6,
      T     = 6'd7,
      O     = 6'd8,
      N     = 6'd9,
      D     = 6'd10,
      M     = 6'd11,
      I     = 6'd12,
      Z     = 6'd13,
      B     = 6'd14,
      K     = 6'd15,
      Y     = 6'd16,
      U     = 6'd17,
      W     = 6'd18,
      L     = 6'd19
   } letter_t;

   // first code the bitmap cannot draw
   localparam logic [LETTER_W-1:0] LETTER_LIMIT = 6'd20;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REVEAL = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   typedef logic [1:0] msg_idx_t;

endpackage

// File: rtl/game_text_rom.sv
// Combinational message ROM: (message, cell index) -> letter code.
// Ports:
//   msg  - message selector (0 BRICKS, 1 PRESS START, 2 YOU WIN, 3 YOU LOSE)
//   idx  - character cell index; cells past the end of a message are blank
//   code - letter code, anything the bitmap cannot draw is returned as blank
module game_text_rom
   import game_text_pkg::*;
(
   input  msg_idx_t              msg,
   input  logic [10:0]           idx,
   output logic [LETTER_W-1:0]   code
);

   letter_t ch;

   always_comb begin
      ch = BLANK;
      case (msg)
         2'd0: begin
            case (idx)
               11'd0:   ch = B;
               11'd1:   ch = R;
               11'd2:   ch = I;
               11'd3:   ch = C;
               11'd4:   ch = K;
               11'd5:   ch = S;
               default: ch = BLANK;
            endcase
         end
         2'd1: begin
            case (idx)
               11'd0:   ch = P;
               11'd1:   ch = R;
               11'd2:   ch = E;
               11'd3:   ch = S;
               11'd4:   ch = S;
               11'd5:   ch = BLANK;
               11'd6:   ch = S;
               11'd7:   ch = T;
               11'd8:   ch = A;
               11'd9:   ch = R;
               11'd10:  ch = T;
               default: ch = BLANK;
            endcase
         end
         2'd2: begin
            case (idx)
               11'd0:   ch = Y;
               11'd1:   ch = O;
               11'd2:   ch = U;
               11'd3:   ch = BLANK;
               11'd4:   ch = W;
               11'd5:   ch = I;
               11'd6:   ch = N;
               default: ch = BLANK;
            endcase
         end
         2'd3: begin
            case (idx)
               11'd0:   ch = Y;
               11'd1:   ch = O;
               11'd2:   ch = U;
               11'd3:   ch = BLANK;
               11'd4:   ch = L;
               11'd5:   ch = O;
               11'd6:   ch = S;
               11'd7:   ch = E;
               default: ch = BLANK;
            endcase
         end
      endcase

      if (ch >= LETTER_LIMIT) code = '0;
      else                    code = ch;
   end

endmodule

// File: rtl/game_text_line_driver.sv
// Pixel-side driver for the letter bitmap: maps the VGA pixel coordinate to
// a character cell, letter code and in-cell offsets, and plays a typewriter
// reveal of one of four messages (one more character every
// CHAR_DELAY_FRAMES frames, then hold).
// Ports:
//   clk, reset          - pixel clock, synchronous active-high reset
//   pixelX, pixelY      - current pixel coordinate
//   startOfFrame        - one pulse per frame, paces the reveal
//   start, clear        - begin reveal of msgSel / blank and go idle
//   msgSel              - message latched on start
//   letter, offsetX,
//   offsetY,
//   InsideRectangle     - registered bitmap inputs, one cycle after the pixel
//   busy, done          - revealing / holding the full message
// Optional build macro TEXT_BLINK_EN: blinks the held message with a
// half-period of BLINK_FRAMES frames.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | nothing displayed, waiting for start
// ST_REVEAL | cells 0..reveal_q-1 displayed, reveal advancing
// ST_HOLD   | whole line displayed until start/clear
module game_text_line_driver
   import game_text_pkg::*;
#(
   parameter logic [10:0] TOP_LEFT_X        = 11'd128,
   parameter logic [10:0] TOP_LEFT_Y        = 11'd200,
   parameter int          SCALE_SHIFT       = 2,
   parameter int          NUM_CHARS         = 16,
   parameter int          CHAR_DELAY_FRAMES = 8,
   parameter int          BLINK_FRAMES      = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [10:0]           pixelX,
   input  logic [10:0]           pixelY,
   input  logic                  startOfFrame,
   input  logic                  start,
   input  logic                  clear,
   input  logic [1:0]            msgSel,
   output logic [LETTER_W-1:0]   letter,
   output logic [10:0]           offsetX,
   output logic [10:0]           offsetY,
   output logic                  InsideRectangle,
   output logic                  busy,
   output logic                  done
);

   localparam int CELL_W    = 8 << SCALE_SHIFT;
   localparam int CELL_H    = 16 << SCALE_SHIFT;
   localparam int IDX_SHIFT = 3 + SCALE_SHIFT;
   localparam int X_END     = int'(TOP_LEFT_X) + NUM_CHARS * CELL_W;
   localparam int Y_END     = int'(TOP_LEFT_Y) + CELL_H;
   localparam int RC_W      = $clog2(NUM_CHARS + 1);
   localparam int FT_W      = (CHAR_DELAY_FRAMES > 1) ? $clog2(CHAR_DELAY_FRAMES) : 1;

   localparam logic [RC_W-1:0] RC_FULL    = RC_W'(NUM_CHARS);
   localparam logic [FT_W-1:0] FT_LOAD    = FT_W'(CHAR_DELAY_FRAMES - 1);
   localparam logic [10:0]     OFF_X_MASK = 11'(CELL_W - 1);
   localparam logic [10:0]     OFF_Y_MASK = 11'(CELL_H - 1);

   state_t                state_q, state_d;
   msg_idx_t              msg_q, msg_d;
   logic [RC_W-1:0]       reveal_q, reveal_d;
   logic [FT_W-1:0]       ftmr_q, ftmr_d;

   logic                  in_line;
   logic [10:0]           rel_x, rel_y;
   logic [10:0]           cell_idx;
   logic [LETTER_W-1:0]   rom_code;
   logic                  shown;
   logic                  blank_blink;

   // ---------------- geometry ----------------
   // bounds are checked on the raw coordinate so the wrapped subtraction
   // below can never produce a false hit left of / above the line
   always_comb begin
      in_line = (int'(pixelX) >= int'(TOP_LEFT_X)) && (int'(pixelX) < X_END) &&
                (int'(pixelY) >= int'(TOP_LEFT_Y)) && (int'(pixelY) < Y_END);
      rel_x    = pixelX - TOP_LEFT_X;
      rel_y    = pixelY - TOP_LEFT_Y;
      cell_idx = rel_x >> IDX_SHIFT;
   end

   game_text_rom u_rom (
      .msg  (msg_q),
      .idx  (cell_idx),
      .code (rom_code)
   );

   // ---------------- sequencing FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         msg_q    <= '0;
         reveal_q <= '0;
         ftmr_q   <= '0;
      end else begin
         state_q  <= state_d;
         msg_q    <= msg_d;
         reveal_q <= reveal_d;
         ftmr_q   <= ftmr_d;
      end
   end

   // frame timer is a down-counter: reloaded on start, next cell revealed
   // on the frame pulse that finds it at zero
   always_comb begin
      state_d  = state_q;
      msg_d    = msg_q;
      reveal_d = reveal_q;
      ftmr_d   = ftmr_q;
      if (clear) begin
         state_d  = ST_IDLE;
         reveal_d = '0;
         ftmr_d   = '0;
      end else if (start) begin
         msg_d    = msgSel;
         reveal_d = RC_W'(1);
         ftmr_d   = FT_LOAD;
         state_d  = (NUM_CHARS == 1) ? ST_HOLD : ST_REVEAL;
      end else if (state_q == ST_REVEAL && startOfFrame) begin
         if (ftmr_q == '0) begin
            ftmr_d   = FT_LOAD;
            reveal_d = reveal_q + RC_W'(1);
            if (reveal_d == RC_FULL) state_d = ST_HOLD;
         end else begin
            ftmr_d = ftmr_q - FT_W'(1);
         end
      end
   end

   assign busy = (state_q == ST_REVEAL);
   assign done = (state_q == ST_HOLD);

   // ---------------- optional blink in HOLD ----------------
`ifdef TEXT_BLINK_EN
   localparam int BT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BT_W-1:0] BT_LOAD = BT_W'(BLINK_FRAMES - 1);

   logic [BT_W-1:0] btmr_q, btmr_d;
   logic            phase_q, phase_d;

   // anything other than staying in HOLD re-arms the timer with phase 0,
   // so every entry into HOLD starts visible
   always_comb begin
      btmr_d  = btmr_q;
      phase_d = phase_q;
      if (state_q == ST_HOLD && state_d == ST_HOLD) begin
         if (startOfFrame) begin
            if (btmr_q == '0) begin
               btmr_d  = BT_LOAD;
               phase_d = ~phase_q;
            end else begin
               btmr_d = btmr_q - BT_W'(1);
            end
         end
      end else begin
         btmr_d  = BT_LOAD;
         phase_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btmr_q  <= BT_LOAD;
         phase_q <= 1'b0;
      end else begin
         btmr_q  <= btmr_d;
         phase_q <= phase_d;
      end
   end

   assign blank_blink = phase_q;
`else
   assign blank_blink = 1'b0;

   // blink period only matters when the blink option is built in
   if (BLINK_FRAMES < 1) begin : g_blink_frames_unused
   end
`endif

   // ---------------- output registers ----------------
   assign shown = in_line && (cell_idx < 11'(reveal_q)) && (state_q != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         letter          <= '0;
         offsetX         <= '0;
         offsetY         <= '0;
         InsideRectangle <= 1'b0;
      end else begin
         letter          <= shown ? rom_code : '0;
         offsetX         <= rel_x & OFF_X_MASK;
         offsetY         <= rel_y & OFF_Y_MASK;
         InsideRectangle <= shown && !blank_blink;
      end
   end

endmodule
